// File: rtl/cp0_regfile_if.sv
// CP0 access bus: the EX-stage read port and the MEM-stage MTC0 commit port.
interface cp0_regfile_if;
  logic        ex_cp0_r_ena;
  logic [7:0]  ex_cp0_r_addr;
  logic [31:0] ex_cp0_r_data;
  logic        mem_w_cp0_ena;
  logic [7:0]  mem_w_cp0_addr;
  logic [31:0] mem_w_cp0_data;

  modport master (
    output ex_cp0_r_ena, ex_cp0_r_addr, mem_w_cp0_ena, mem_w_cp0_addr, mem_w_cp0_data,
    input  ex_cp0_r_data
  );

  modport slave (
    input  ex_cp0_r_ena, ex_cp0_r_addr, mem_w_cp0_ena, mem_w_cp0_addr, mem_w_cp0_data,
    output ex_cp0_r_data
  );
endinterface

// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file: BadVAddr, Count, Compare, Status, Cause, EPC plus interrupt request.
// Define CP0_TIMER_INT_EN to let Count==Compare raise Cause.TI and IP[7].
module cp0_regfile #(
  parameter logic [31:0] STATUS_RST = 32'h0040_0000,
  parameter bit          COUNT_HALF = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  cp0_regfile_if.slave bus,
  input  logic        exc_valid,
  input  logic        exc_is_eret,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        exc_in_delay_slot,
  input  logic        exc_badvaddr_ena,
  input  logic [31:0] exc_badvaddr,
  input  logic [5:0]  ext_int,
  output logic [31:0] cp0_epc,
  output logic [31:0] cp0_status,
  output logic [31:0] cp0_cause,
  output logic        cp0_int_req
);
  localparam logic [7:0] A_BADVADDR = 8'h40;
  localparam logic [7:0] A_COUNT    = 8'h48;
  localparam logic [7:0] A_COMPARE  = 8'h58;
  localparam logic [7:0] A_STATUS   = 8'h60;
  localparam logic [7:0] A_CAUSE    = 8'h68;
  localparam logic [7:0] A_EPC      = 8'h70;

  logic [31:0] status_reg, epc_reg, badvaddr_reg, count_reg, compare_reg;
  logic        bd_reg, tick_reg;
  logic [5:0]  ip_hw_reg;
  logic [1:0]  ip_sw_reg;
  logic [4:0]  exc_code_reg;
  logic        ti;

  logic        w_eff, wr_count, wr_compare, wr_status, wr_cause, wr_epc, count_inc;
  logic [31:0] status_wval, cause_val, cause_wval;

  // An exception or ERET in the same cycle swallows the MTC0, including its read bypass.
  always_comb begin
    w_eff       = bus.mem_w_cp0_ena & ~exc_valid;
    wr_count    = w_eff && (bus.mem_w_cp0_addr == A_COUNT);
    wr_compare  = w_eff && (bus.mem_w_cp0_addr == A_COMPARE);
    wr_status   = w_eff && (bus.mem_w_cp0_addr == A_STATUS);
    wr_cause    = w_eff && (bus.mem_w_cp0_addr == A_CAUSE);
    wr_epc      = w_eff && (bus.mem_w_cp0_addr == A_EPC);
    count_inc   = COUNT_HALF ? tick_reg : 1'b1;
    status_wval = (bus.mem_w_cp0_data & 32'h0000_FF03) | 32'h0040_0000;
    cause_val   = {bd_reg, ti, 14'b0, ip_hw_reg[5] | ti, ip_hw_reg[4:0],
                   ip_sw_reg, 1'b0, exc_code_reg, 2'b00};
    cause_wval  = {cause_val[31:10], bus.mem_w_cp0_data[9:8], cause_val[7:0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_reg   <= STATUS_RST;
      epc_reg      <= '0;
      badvaddr_reg <= '0;
      count_reg    <= '0;
      compare_reg  <= '0;
      bd_reg       <= 1'b0;
      tick_reg     <= 1'b0;
      ip_hw_reg    <= '0;
      ip_sw_reg    <= '0;
      exc_code_reg <= '0;
    end else begin
      ip_hw_reg <= ext_int;
      if (wr_count) begin
        count_reg <= bus.mem_w_cp0_data;
        tick_reg  <= 1'b0;
      end else begin
        tick_reg <= ~tick_reg;
        if (count_inc)
          count_reg <= count_reg + 32'd1;
      end
      if (wr_compare) compare_reg <= bus.mem_w_cp0_data;
      if (wr_status)  status_reg  <= status_wval;
      if (wr_cause)   ip_sw_reg   <= bus.mem_w_cp0_data[9:8];
      if (wr_epc)     epc_reg     <= bus.mem_w_cp0_data;
      if (exc_valid) begin
        if (exc_is_eret) begin
          status_reg[1] <= 1'b0;
        end else begin
          status_reg[1] <= 1'b1;
          exc_code_reg  <= exc_code;
          // A nested exception keeps the EPC/BD of the original one.
          if (!status_reg[1]) begin
            epc_reg <= exc_in_delay_slot ? exc_pc - 32'd4 : exc_pc;
            bd_reg  <= exc_in_delay_slot;
          end
          if (exc_badvaddr_ena) badvaddr_reg <= exc_badvaddr;
        end
      end
    end
  end

`ifdef CP0_TIMER_INT_EN
  logic ti_reg;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ti_reg <= 1'b0;
    else if (wr_compare)
      ti_reg <= 1'b0;
    else if (count_reg == compare_reg)
      ti_reg <= 1'b1;
  end
  assign ti = ti_reg;
`else
  assign ti = 1'b0;
`endif

  always_comb begin
    bus.ex_cp0_r_data = 32'h0;
    if (bus.ex_cp0_r_ena && !rst) begin
      unique case (bus.ex_cp0_r_addr)
        A_BADVADDR: bus.ex_cp0_r_data = badvaddr_reg;
        A_COUNT:    bus.ex_cp0_r_data = wr_count   ? bus.mem_w_cp0_data : count_reg;
        A_COMPARE:  bus.ex_cp0_r_data = wr_compare ? bus.mem_w_cp0_data : compare_reg;
        A_STATUS:   bus.ex_cp0_r_data = wr_status  ? status_wval : status_reg;
        A_CAUSE:    bus.ex_cp0_r_data = wr_cause   ? cause_wval  : cause_val;
        A_EPC:      bus.ex_cp0_r_data = wr_epc     ? bus.mem_w_cp0_data : epc_reg;
        default:    bus.ex_cp0_r_data = 32'h0;
      endcase
    end
  end

  assign cp0_epc     = epc_reg;
  assign cp0_status  = status_reg;
  assign cp0_cause   = cause_val;
  assign cp0_int_req = status_reg[0] & ~status_reg[1] & |(cause_val[15:8] & status_reg[15:8]);
endmodule
